// File: rtl/latq_bank_writer.sv
// Write sequencer for a bank of transparent latches: turns a one-cycle request
// into setup / one-hot enable pulse / hold, with every output registered.
module latq_bank_writer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AW       = 2,
  parameter int unsigned E_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ,
  input  logic [AW-1:0]    ADDR,
  input  logic [WIDTH-1:0] WDATA,
  output logic             READY,
  output logic             ACK,
  output logic             ERR,
  output logic [WIDTH-1:0] D,
  output logic [DEPTH-1:0] E
);

  localparam int unsigned   CW       = $clog2(E_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(E_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(E_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t           state_q, state_n;
  logic [AW-1:0]    addr_q, addr_n;
  logic             in_range_q, in_range_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [WIDTH-1:0] d_n;
  logic [DEPTH-1:0] e_n;
  logic             ready_n, ack_n, err_n;

  always_comb begin
    state_n    = state_q;
    addr_n     = addr_q;
    in_range_n = in_range_q;
    cnt_n      = cnt_q;
    d_n        = D;
    case (state_q)
      IDLE: begin
        if (REQ) begin
          state_n    = SETUP;
          addr_n     = ADDR;
          d_n        = WDATA;
          in_range_n = 1'b0;
          for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ADDR == AW'(i)) in_range_n = 1'b1;
          end
        end
      end
      SETUP: begin
        state_n = PULSE;
        cnt_n   = '0;
      end
      PULSE: begin
        if (cnt_q != CNT_MAX) cnt_n = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_n = HOLD;
      end
      HOLD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight from flops.
    e_n = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      e_n[i] = (state_n == PULSE) && in_range_n && (addr_n == AW'(i));
    end
    ready_n = (state_n == IDLE);
    ack_n   = (state_n == HOLD);
    err_n   = (state_n == HOLD) && !in_range_n;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      in_range_q <= 1'b0;
      cnt_q      <= '0;
      D          <= '0;
      E          <= '0;
      READY      <= 1'b1;
      ACK        <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      state_q    <= state_n;
      addr_q     <= addr_n;
      in_range_q <= in_range_n;
      cnt_q      <= cnt_n;
      D          <= d_n;
      E          <= e_n;
      READY      <= ready_n;
      ACK        <= ack_n;
      ERR        <= err_n;
    end
  end

endmodule

// File: tb/tb_latq_bank_writer.sv
// Bench for latq_bank_writer: directed vector table, corner sequences and
// random traffic against a timeline-based reference model with latch models.
module tb_latq_bank_writer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int AW    = 2;
  localparam int EC    = 3;

  logic             clk = 1'b0;
  logic             rst, req;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wdata;
  logic             ready, ack, err;
  logic [WIDTH-1:0] d;
  logic [DEPTH-1:0] e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  latq_bank_writer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .E_CYCLES(EC)
  ) dut (
    .CLK(clk), .RST(rst), .REQ(req), .ADDR(addr), .WDATA(wdata),
    .READY(ready), .ACK(ack), .ERR(err), .D(d), .E(e)
  );

  // Reference: k = cycles since the accepted request (0 = idle).
  int               k = 0;
  int               m_addr = 0;
  logic [WIDTH-1:0] m_data = '0;
  logic [WIDTH-1:0] m_d = '0;
  logic [WIDTH-1:0] lat     [DEPTH];
  logic [WIDTH-1:0] mem_exp [DEPTH];
  int               model_acks = 0;
  int               dut_acks = 0;
  int               zero_run = 0;
  int               last_gap = -1;
  bit               seen_pulse = 0;

  typedef struct {
    logic             rst, req;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic             ready, ack, err;
    logic [DEPTH-1:0] e;
    logic [WIDTH-1:0] d;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic q, input logic [AW-1:0] a,
                     input logic [WIDTH-1:0] w);
    logic [DEPTH-1:0] ee;
    logic             exp_ack, exp_err;
    rst = r; req = q; addr = a; wdata = w;
    @(posedge clk);
    if (r) begin
      k = 0;
      m_d = '0;
    end else if (k == 0) begin
      if (q) begin
        k = 1; m_addr = int'(a); m_data = w; m_d = w;
      end
    end else if (k == 2 + EC) begin
      k = 0;
    end else begin
      k = k + 1;
    end
    @(negedge clk);
    ee = '0;
    if (k >= 2 && k <= 1 + EC && m_addr < DEPTH) ee[m_addr] = 1'b1;
    exp_ack = (k == 2 + EC);
    exp_err = exp_ack && (m_addr >= DEPTH);
    if (k == 2 && m_addr < DEPTH) mem_exp[m_addr] = m_data;
    check("model", {ready, ack, err, e, d}, {(k == 0), exp_ack, exp_err, ee, m_d});
    for (int i = 0; i < DEPTH; i++) if (e[i]) lat[i] = d;
    if (ack) dut_acks++;
    if (exp_ack) begin
      model_acks++;
      if (m_addr < DEPTH) check("latch_at_ack", lat[m_addr], m_data);
    end
    if (e != '0) begin
      if (seen_pulse && zero_run > 0) last_gap = zero_run;
      seen_pulse = 1;
      zero_run = 0;
    end else begin
      zero_run++;
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 20) begin
      cyc(1'b0, 1'b0, '0, '0);
      n++;
    end
    if (!ready) check(name, 0, 1);
  endtask

  initial begin
    logic [WIDTH-1:0] l1;
    int               acks0;
    rst = 1'b1; req = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lat[i] = '0;
      mem_exp[i] = '0;
    end

    //            rst req addr wdata   | rdy ack err e       d
    tbl[0]  = '{1, 0, 0, 8'h00, 1, 0, 0, 3'b000, 8'h00};
    tbl[1]  = '{1, 0, 0, 8'h00, 1, 0, 0, 3'b000, 8'h00};
    tbl[2]  = '{0, 0, 0, 8'h00, 1, 0, 0, 3'b000, 8'h00};
    tbl[3]  = '{0, 1, 2, 8'hA5, 0, 0, 0, 3'b000, 8'hA5};
    tbl[4]  = '{0, 0, 0, 8'h00, 0, 0, 0, 3'b100, 8'hA5};
    tbl[5]  = '{0, 0, 0, 8'h00, 0, 0, 0, 3'b100, 8'hA5};
    tbl[6]  = '{0, 0, 0, 8'h00, 0, 0, 0, 3'b100, 8'hA5};
    tbl[7]  = '{0, 0, 0, 8'h00, 0, 1, 0, 3'b000, 8'hA5};
    tbl[8]  = '{0, 0, 0, 8'h00, 1, 0, 0, 3'b000, 8'hA5};
    tbl[9]  = '{0, 1, 3, 8'hFF, 0, 0, 0, 3'b000, 8'hFF};
    tbl[10] = '{0, 0, 0, 8'h00, 0, 0, 0, 3'b000, 8'hFF};
    tbl[11] = '{0, 0, 0, 8'h00, 0, 0, 0, 3'b000, 8'hFF};
    tbl[12] = '{0, 0, 0, 8'h00, 0, 0, 0, 3'b000, 8'hFF};
    tbl[13] = '{0, 0, 0, 8'h00, 0, 1, 1, 3'b000, 8'hFF};
    tbl[14] = '{0, 0, 0, 8'h00, 1, 0, 0, 3'b000, 8'hFF};
    tbl[15] = '{0, 1, 0, 8'h5A, 0, 0, 0, 3'b000, 8'h5A};
    tbl[16] = '{0, 1, 1, 8'h33, 0, 0, 0, 3'b001, 8'h5A};
    tbl[17] = '{1, 0, 0, 8'h00, 1, 0, 0, 3'b000, 8'h00};
    tbl[18] = '{1, 1, 1, 8'h77, 1, 0, 0, 3'b000, 8'h00};
    tbl[19] = '{0, 0, 0, 8'h00, 1, 0, 0, 3'b000, 8'h00};

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].rst, tbl[i].req, tbl[i].addr, tbl[i].wdata);
      check($sformatf("vec%0d", i), {ready, ack, err, e, d},
            {tbl[i].ready, tbl[i].ack, tbl[i].err, tbl[i].e, tbl[i].d});
    end
    check("latch2_A5", lat[2], 8'hA5);

    // Back-to-back: second request issued on the first READY cycle.
    seen_pulse = 0; zero_run = 0; last_gap = -1;
    cyc(1'b0, 1'b1, 2'd0, 8'h11);
    cyc(1'b0, 1'b0, '0, '0);
    wait_ready("b2b_timeout1");
    cyc(1'b0, 1'b1, 2'd2, 8'h22);
    cyc(1'b0, 1'b0, '0, '0);
    wait_ready("b2b_timeout2");
    check("b2b_gap_ge2", (last_gap >= 2), 1);
    check("b2b_lat0", lat[0], 8'h11);
    check("b2b_lat2", lat[2], 8'h22);

    // Busy drop: request held through SETUP and PULSE of a prior write.
    l1 = lat[1];
    acks0 = dut_acks;
    cyc(1'b0, 1'b1, 2'd0, 8'h44);
    for (int j = 0; j < 1 + EC; j++) cyc(1'b0, 1'b1, 2'd1, 8'h33);
    cyc(1'b0, 1'b0, '0, '0);
    wait_ready("busy_timeout");
    check("busy_lat1_kept", lat[1], l1);
    check("busy_lat0", lat[0], 8'h44);
    check("busy_one_ack", dut_acks - acks0, 1);

    // Random traffic including occasional resets and out-of-range addresses.
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
          AW'($urandom_range(0, 3)), WIDTH'($urandom));
    end
    for (int i = 0; i < DEPTH; i++) check($sformatf("final_lat%0d", i), lat[i], mem_exp[i]);
    check("ack_total", dut_acks, model_acks);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
